// File: rtl/reg_scoreboard_pkg.sv
// Shared defaults and helpers for the register-busy scoreboard.
package scoreboard_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 2;

    // Largest count a CNT_W-bit pending counter can hold.
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/source-check bundle between the pipeline and the scoreboard.
interface reg_scoreboard_if #(
    parameter int ADDR_W = 5
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic                i_set_en;
    logic [ADDR_W-1:0]   i_set_addr;
    logic                i_clr_en;
    logic [ADDR_W-1:0]   i_clr_addr;
    logic [ADDR_W-1:0]   i_rs1_addr;
    logic [ADDR_W-1:0]   i_rs2_addr;
    logic                o_rs1_busy;
    logic                o_rs2_busy;
    logic                o_stall;
    logic                o_set_full;
    logic [NUM_REGS-1:0] o_busy_vec;
    logic                o_err;

    modport master (
        output i_set_en, i_set_addr, i_clr_en, i_clr_addr, i_rs1_addr, i_rs2_addr,
        input  o_rs1_busy, o_rs2_busy, o_stall, o_set_full, o_busy_vec, o_err
    );

    modport slave (
        input  i_set_en, i_set_addr, i_clr_en, i_clr_addr, i_rs1_addr, i_rs2_addr,
        output o_rs1_busy, o_rs2_busy, o_stall, o_set_full, o_busy_vec, o_err
    );

endinterface

// File: rtl/reg_scoreboard_decoder.sv
// Enable-gated binary to one-hot decoder.
module decoder_onehot #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic                   i_enable,
    output logic [2**ADDR_W-1:0]   o_select
);

    // Exactly one select bit when enabled, none otherwise.
    always_comb begin
        o_select = '0;
        if (i_enable) o_select[i_addr] = 1'b1;
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard: saturating pending-write counter per register,
// combinational source-hazard checks and a sticky protocol error flag.
module reg_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    parameter bit ZERO_HARDWIRED = 1'b1,
    parameter bit FWD_CLR        = 1'b1
) (
    input logic             i_clk,
    input logic             i_reset,
    reg_scoreboard_if.slave sb
);

    localparam int               NUM_REGS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [NUM_REGS-1:0]            set_dec, clr_dec, set_sel, clr_sel, keep_mask;
    logic [NUM_REGS-1:0][CNT_W-1:0] count, count_nxt;
    logic                           err_q, ovf, unf;
    logic [CNT_W-1:0]               rs1_cnt, rs2_cnt;
    logic                           rs1_fwd, rs2_fwd;

    decoder_onehot #(.ADDR_W(ADDR_W)) u_set_dec (
        .i_addr   (sb.i_set_addr),
        .i_enable (sb.i_set_en),
        .o_select (set_dec)
    );

    decoder_onehot #(.ADDR_W(ADDR_W)) u_clr_dec (
        .i_addr   (sb.i_clr_addr),
        .i_enable (sb.i_clr_en),
        .o_select (clr_dec)
    );

    // Register 0 is masked out of both decodes so it can never count or error.
    assign keep_mask = ZERO_HARDWIRED ? {{(NUM_REGS-1){1'b1}}, 1'b0} : {NUM_REGS{1'b1}};
    assign set_sel   = set_dec & keep_mask;
    assign clr_sel   = clr_dec & keep_mask;

    // Next count per register; set+clear on the same register cancels out.
    always_comb begin
        count_nxt = count;
        ovf       = 1'b0;
        unf       = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (set_sel[r] && !clr_sel[r]) begin
                if (count[r] == MAX_CNT) ovf = 1'b1;
                else                     count_nxt[r] = count[r] + ONE_CNT;
            end else if (clr_sel[r] && !set_sel[r]) begin
                if (count[r] == '0) unf = 1'b1;
                else                count_nxt[r] = count[r] - ONE_CNT;
            end
        end
    end

    // Counter array and sticky error; reset discards all pending writes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
            err_q <= 1'b0;
        end else begin
            count <= count_nxt;
            if (ovf || unf) err_q <= 1'b1;
        end
    end

    // Busy vector straight from registered counts.
    always_comb begin
        sb.o_busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) sb.o_busy_vec[r] = (count[r] != '0);
    end

    // A writeback retiring the last pending write lets the source read proceed
    // this cycle; a same-cycle issue is invisible until the next edge.
    assign rs1_cnt = count[sb.i_rs1_addr];
    assign rs2_cnt = count[sb.i_rs2_addr];
    assign rs1_fwd = FWD_CLR && sb.i_clr_en && (sb.i_clr_addr == sb.i_rs1_addr) && (rs1_cnt == ONE_CNT);
    assign rs2_fwd = FWD_CLR && sb.i_clr_en && (sb.i_clr_addr == sb.i_rs2_addr) && (rs2_cnt == ONE_CNT);

    assign sb.o_rs1_busy = (rs1_cnt != '0) && !rs1_fwd;
    assign sb.o_rs2_busy = (rs2_cnt != '0) && !rs2_fwd;
    assign sb.o_set_full = (count[sb.i_set_addr] == MAX_CNT);
    assign sb.o_stall    = sb.o_rs1_busy | sb.o_rs2_busy | sb.o_set_full;
    assign sb.o_err      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench: table of per-cycle vectors plus hand sequences for reset.
// Instance a has register 0 hardwired, instance b treats it as ordinary.
module tb_reg_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    reg_scoreboard_if #(.ADDR_W(5)) if_a ();
    reg_scoreboard_if #(.ADDR_W(5)) if_b ();

    reg_scoreboard #(.ADDR_W(5), .CNT_W(2), .ZERO_HARDWIRED(1'b1), .FWD_CLR(1'b1)) dut_a (
        .i_clk (clk), .i_reset (rst), .sb (if_a)
    );

    reg_scoreboard #(.ADDR_W(5), .CNT_W(2), .ZERO_HARDWIRED(1'b0), .FWD_CLR(1'b1)) dut_b (
        .i_clk (clk), .i_reset (rst), .sb (if_b)
    );

    typedef struct {
        logic        se;
        logic [4:0]  sa;
        logic        ce;
        logic [4:0]  ca;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_r1;
        logic        e_r2;
        logic        e_full;
        logic        e_stall;
        logic        e_err;
        logic [31:0] e_vec;
        logic        b_r1;
        logic [31:0] b_vec;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic se, input logic [4:0] sa, input logic ce,
                                input logic [4:0] ca, input logic [4:0] r1, input logic [4:0] r2,
                                input logic er1, input logic er2, input logic ef, input logic est,
                                input logic eerr, input logic [31:0] evec,
                                input logic br1, input logic [31:0] bvec);
        vec_t v;
        v.se = se; v.sa = sa; v.ce = ce; v.ca = ca; v.r1 = r1; v.r2 = r2;
        v.e_r1 = er1; v.e_r2 = er2; v.e_full = ef; v.e_stall = est; v.e_err = eerr;
        v.e_vec = evec; v.b_r1 = br1; v.b_vec = bvec;
        return v;
    endfunction

    task automatic drive(input logic se, input logic [4:0] sa, input logic ce,
                         input logic [4:0] ca, input logic [4:0] r1, input logic [4:0] r2);
        if_a.i_set_en = se; if_a.i_set_addr = sa; if_a.i_clr_en = ce; if_a.i_clr_addr = ca;
        if_a.i_rs1_addr = r1; if_a.i_rs2_addr = r2;
        if_b.i_set_en = se; if_b.i_set_addr = sa; if_b.i_clr_en = ce; if_b.i_clr_addr = ca;
        if_b.i_rs1_addr = r1; if_b.i_rs2_addr = r2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);

        // Hazard on r5, then forwarded clear.
        tv.push_back(mk(1,5,0,0,5,0, 0,0,0,0,0, 32'h0,   0,32'h0));
        tv.push_back(mk(0,0,0,0,5,0, 1,0,0,1,0, 32'h20,  1,32'h20));
        tv.push_back(mk(0,0,1,5,5,0, 0,0,0,0,0, 32'h20,  0,32'h20));
        tv.push_back(mk(0,0,0,0,5,0, 0,0,0,0,0, 32'h0,   0,32'h0));
        // Simultaneous set/clear on r9.
        tv.push_back(mk(1,9,0,0,0,0, 0,0,0,0,0, 32'h0,   0,32'h0));
        tv.push_back(mk(1,9,1,9,9,0, 0,0,0,0,0, 32'h200, 0,32'h200));
        tv.push_back(mk(0,0,0,0,9,0, 1,0,0,1,0, 32'h200, 1,32'h200));
        tv.push_back(mk(0,0,1,9,0,9, 0,0,0,0,0, 32'h200, 0,32'h200));
        tv.push_back(mk(1,9,1,9,9,0, 0,0,0,0,0, 32'h0,   0,32'h0));
        tv.push_back(mk(0,0,0,0,9,0, 0,0,0,0,0, 32'h0,   0,32'h0));
        // Register 0: ignored in a, ordinary in b.
        tv.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0, 32'h0,   0,32'h0));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 32'h0,   1,32'h1));
        tv.push_back(mk(0,0,1,0,0,0, 0,0,0,0,0, 32'h0,   0,32'h1));
        tv.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0, 32'h0,   0,32'h0));
        // Saturation and overflow on r7, then drain.
        tv.push_back(mk(1,7,0,0,0,0, 0,0,0,0,0, 32'h0,   0,32'h0));
        tv.push_back(mk(1,7,0,0,0,0, 0,0,0,0,0, 32'h80,  0,32'h80));
        tv.push_back(mk(1,7,0,0,0,0, 0,0,0,0,0, 32'h80,  0,32'h80));
        tv.push_back(mk(1,7,0,0,0,0, 0,0,1,1,0, 32'h80,  0,32'h80));
        tv.push_back(mk(0,7,0,0,7,0, 1,0,1,1,1, 32'h80,  1,32'h80));
        tv.push_back(mk(0,0,1,7,0,7, 0,1,0,1,1, 32'h80,  0,32'h80));
        tv.push_back(mk(0,0,1,7,0,7, 0,1,0,1,1, 32'h80,  0,32'h80));
        tv.push_back(mk(0,0,1,7,0,7, 0,0,0,0,1, 32'h80,  0,32'h80));
        tv.push_back(mk(0,0,0,0,0,7, 0,0,0,0,1, 32'h0,   0,32'h0));

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset busy_vec", if_a.o_busy_vec, 32'h0);
        chk("reset stall",    {31'b0, if_a.o_stall}, 32'h0);
        chk("reset err",      {31'b0, if_a.o_err}, 32'h0);
        chk("reset rs1",      {31'b0, if_a.o_rs1_busy}, 32'h0);
        rst = 1'b0;

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].se, tv[i].sa, tv[i].ce, tv[i].ca, tv[i].r1, tv[i].r2);
            #1;
            chk($sformatf("v%0d rs1", i),   {31'b0, if_a.o_rs1_busy}, {31'b0, tv[i].e_r1});
            chk($sformatf("v%0d rs2", i),   {31'b0, if_a.o_rs2_busy}, {31'b0, tv[i].e_r2});
            chk($sformatf("v%0d full", i),  {31'b0, if_a.o_set_full}, {31'b0, tv[i].e_full});
            chk($sformatf("v%0d stall", i), {31'b0, if_a.o_stall}, {31'b0, tv[i].e_stall});
            chk($sformatf("v%0d err", i),   {31'b0, if_a.o_err}, {31'b0, tv[i].e_err});
            chk($sformatf("v%0d vec", i),   if_a.o_busy_vec, tv[i].e_vec);
            chk($sformatf("v%0d b rs1", i), {31'b0, if_b.o_rs1_busy}, {31'b0, tv[i].b_r1});
            chk($sformatf("v%0d b vec", i), if_b.o_busy_vec, tv[i].b_vec);
            chk($sformatf("v%0d b err", i), {31'b0, if_b.o_err}, {31'b0, tv[i].e_err});
        end

        // Async reset between edges clears the sticky error.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk("async rst err", {31'b0, if_a.o_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Underflow on r3 sets a sticky error.
        drive(0, 0, 1, 3, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 chk("underflow err", {31'b0, if_a.o_err}, 32'h1);
        @(negedge clk);
        drive(1, 3, 0, 0, 0, 0);
        #1 chk("err sticky", {31'b0, if_a.o_err}, 32'h1);
        @(negedge clk);
        drive(1, 4, 0, 0, 3, 0);
        #1 chk("r3 pending", {31'b0, if_a.o_rs1_busy}, 32'h1);
        @(negedge clk);
        drive(0, 3, 0, 0, 3, 4);
        #1;
        chk("r3r4 vec",   if_a.o_busy_vec, 32'h18);
        chk("r3r4 stall", {31'b0, if_a.o_stall}, 32'h1);

        // Reset mid-operation, then a request in the release cycle.
        #2 rst = 1'b1;
        #1;
        chk("midrst vec",   if_a.o_busy_vec, 32'h0);
        chk("midrst rs1",   {31'b0, if_a.o_rs1_busy}, 32'h0);
        chk("midrst rs2",   {31'b0, if_a.o_rs2_busy}, 32'h0);
        chk("midrst stall", {31'b0, if_a.o_stall}, 32'h0);
        chk("midrst err",   {31'b0, if_a.o_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 4, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 4, 0);
        #1;
        chk("post-rst vec", if_a.o_busy_vec, 32'h10);
        chk("post-rst rs1", {31'b0, if_a.o_rs1_busy}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
